// File: rtl/id_stage_pipe.sv
// Pipelined ID stage: register file with write-through bypass, branch-offset
// generation, load-use stall and ID/EX register. Optional stall counter: ID_STALL_CNT_EN.
module id_stage_pipe #(
   parameter int WIDTH    = 64,
   parameter int NUM_REGS = 32,
   parameter int AW       = $clog2(NUM_REGS),
   parameter int CTRL_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [WIDTH-1:0]  if_pc,
   input  logic [AW-1:0]     rn,
   input  logic [AW-1:0]     rm,
   input  logic [AW-1:0]     rd,
   input  logic              reg2loc,
   input  logic              uses_b,
   input  logic              mem_read,
   input  logic              uncond_br,
   input  logic [18:0]       cond_br_addr,
   input  logic [25:0]       br_addr,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_addr,
   input  logic [WIDTH-1:0]  wb_data,
   input  logic              wb_link_sel,
   input  logic [WIDTH-1:0]  wb_link,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [WIDTH-1:0]  ex_pc,
   output logic [WIDTH-1:0]  ex_da,
   output logic [WIDTH-1:0]  ex_db,
   output logic [WIDTH-1:0]  ex_br_off,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [AW-1:0]     ex_rd,
   output logic              ex_mem_read,
   output logic [31:0]       stall_cnt
);

   localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);

   logic [WIDTH-1:0] rf_q [NUM_REGS];
   logic [WIDTH-1:0] rf_d [NUM_REGS];

   logic [WIDTH-1:0] wr_val;
   logic             wr_en;
   logic [AW-1:0]    addr_b;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic [WIDTH-1:0] imm_sext;
   logic [WIDTH-1:0] br_off;
   logic             haz;

   logic              ex_valid_q, ex_valid_d;
   logic [WIDTH-1:0]  ex_pc_q, ex_pc_d;
   logic [WIDTH-1:0]  ex_da_q, ex_da_d;
   logic [WIDTH-1:0]  ex_db_q, ex_db_d;
   logic [WIDTH-1:0]  ex_br_off_q, ex_br_off_d;
   logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
   logic [AW-1:0]     ex_rd_q, ex_rd_d;
   logic              ex_mem_read_q, ex_mem_read_d;

   always_comb begin
      wr_val = wb_link_sel ? wb_link : wb_data;
      wr_en  = wb_we && (wb_addr != XZR);
      addr_b = reg2loc ? rd : rm;
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         rf_d[i] = rf_q[i];
      end
      if (wr_en) begin
         rf_d[wb_addr] = wr_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   // Write-through: a same-cycle write-back overrides the stored entry
   always_comb begin
      if (rn == XZR)                    rd_a = '0;
      else if (wr_en && wb_addr == rn)  rd_a = wr_val;
      else                              rd_a = rf_q[rn];

      if (addr_b == XZR)                   rd_b = '0;
      else if (wr_en && wb_addr == addr_b) rd_b = wr_val;
      else                                 rd_b = rf_q[addr_b];
   end

   always_comb begin
      if (uncond_br) imm_sext = {{(WIDTH-26){br_addr[25]}}, br_addr};
      else           imm_sext = {{(WIDTH-19){cond_br_addr[18]}}, cond_br_addr};
      br_off = imm_sext << 2;
   end

   always_comb begin
      haz = if_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != XZR) &&
            ((ex_rd_q == rn) || (uses_b && (ex_rd_q == addr_b)));
      stall = haz && !flush && !reset;
   end

   // Flush and stall both inject the same bubble; otherwise decode advances
   always_comb begin
      ex_valid_d    = 1'b0;
      ex_pc_d       = '0;
      ex_da_d       = '0;
      ex_db_d       = '0;
      ex_br_off_d   = '0;
      ex_ctrl_d     = '0;
      ex_rd_d       = XZR;
      ex_mem_read_d = 1'b0;
      if (!(flush || stall)) begin
         ex_valid_d    = if_valid;
         ex_pc_d       = if_pc;
         ex_da_d       = rd_a;
         ex_db_d       = rd_b;
         ex_br_off_d   = br_off;
         ex_ctrl_d     = if_valid ? ctrl_in : '0;
         ex_rd_d       = rd;
         ex_mem_read_d = if_valid && mem_read;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_da_q       <= '0;
         ex_db_q       <= '0;
         ex_br_off_q   <= '0;
         ex_ctrl_q     <= '0;
         ex_rd_q       <= '0;
         ex_mem_read_q <= 1'b0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_da_q       <= ex_da_d;
         ex_db_q       <= ex_db_d;
         ex_br_off_q   <= ex_br_off_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_rd_q       <= ex_rd_d;
         ex_mem_read_q <= ex_mem_read_d;
      end
   end

   always_comb begin
      ex_valid    = ex_valid_q;
      ex_pc       = ex_pc_q;
      ex_da       = ex_da_q;
      ex_db       = ex_db_q;
      ex_br_off   = ex_br_off_q;
      ex_ctrl     = ex_ctrl_q;
      ex_rd       = ex_rd_q;
      ex_mem_read = ex_mem_read_q;
   end

`ifdef ID_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (default parameters).
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [4:0]  rn, rm, rd;
   logic        reg2loc, uses_b, mem_read, uncond_br;
   logic [18:0] cond_br_addr;
   logic [25:0] br_addr;
   logic [7:0]  ctrl_in;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;
   logic        wb_link_sel;
   logic [63:0] wb_link;
   logic        flush;
   logic        stall;
   logic        ex_valid;
   logic [63:0] ex_pc, ex_da, ex_db, ex_br_off;
   logic [7:0]  ex_ctrl;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic [31:0] stall_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_cnt = '0;
   logic [31:0] exp_cnt_out;

   id_stage_pipe #(.WIDTH(64), .NUM_REGS(32), .CTRL_W(8)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
      .rn(rn), .rm(rm), .rd(rd), .reg2loc(reg2loc), .uses_b(uses_b),
      .mem_read(mem_read), .uncond_br(uncond_br), .cond_br_addr(cond_br_addr),
      .br_addr(br_addr), .ctrl_in(ctrl_in), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_link_sel(wb_link_sel), .wb_link(wb_link),
      .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_da(ex_da), .ex_db(ex_db), .ex_br_off(ex_br_off), .ex_ctrl(ex_ctrl),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
`ifdef ID_STALL_CNT_EN
      exp_cnt_out = exp_cnt;
`else
      exp_cnt_out = '0;
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_valid = 0; if_pc = '0; rn = 0; rm = 0; rd = 0; reg2loc = 0; uses_b = 0;
      mem_read = 0; uncond_br = 0; cond_br_addr = '0; br_addr = '0; ctrl_in = '0;
      wb_we = 0; wb_addr = 0; wb_data = '0; wb_link_sel = 0; wb_link = '0; flush = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle();
      step(); step();
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0d want 0", ex_valid); end
      n_cmp++; if (ex_pc !== 64'd0 || ex_da !== 64'd0 || ex_db !== 64'd0 || ex_br_off !== 64'd0)
         begin n_err++; $display("FAIL rst_data got pc=%h da=%h db=%h off=%h want 0", ex_pc, ex_da, ex_db, ex_br_off); end
      n_cmp++; if (ex_ctrl !== 8'd0 || ex_rd !== 5'd0 || ex_mem_read !== 1'b0)
         begin n_err++; $display("FAIL rst_ctrl got ctrl=%h rd=%0d mr=%0d want 0", ex_ctrl, ex_rd, ex_mem_read); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %0d want 0", stall); end
      n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", stall_cnt); end
      reset = 0;
      if_valid = 1; if_pc = 64'h100; rn = 5; rm = 6; rd = 4; ctrl_in = 8'hA5;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL post_rst_stall got %0d want 0", stall); end
      step();
      n_cmp++; if (ex_da !== 64'd0 || ex_db !== 64'd0) begin n_err++; $display("FAIL rst_read got da=%h db=%h want 0", ex_da, ex_db); end
      n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 64'h100 || ex_ctrl !== 8'hA5 || ex_rd !== 5'd4)
         begin n_err++; $display("FAIL first_decode got v=%0d pc=%h ctrl=%h rd=%0d want 1 100 a5 4", ex_valid, ex_pc, ex_ctrl, ex_rd); end
   endtask

   task automatic test_write_through();
      idle(); if_valid = 1; rn = 3; rm = 3; rd = 1;
      wb_we = 1; wb_addr = 3; wb_data = 64'hDEAD;
      step();
      n_cmp++; if (ex_da !== 64'hDEAD || ex_db !== 64'hDEAD) begin n_err++; $display("FAIL wt_bypass got da=%h db=%h want dead", ex_da, ex_db); end
      idle(); if_valid = 1; rn = 5; reg2loc = 1; rd = 3; rm = 9;
      step();
      n_cmp++; if (ex_db !== 64'hDEAD || ex_da !== 64'd0) begin n_err++; $display("FAIL wt_stored got da=%h db=%h want 0 dead", ex_da, ex_db); end
      n_cmp++; if (ex_rd !== 5'd3) begin n_err++; $display("FAIL wt_rd got %0d want 3", ex_rd); end
   endtask

   task automatic test_zero_reg();
      idle(); if_valid = 1; rn = 31; rm = 31;
      wb_we = 1; wb_addr = 31; wb_data = 64'h55;
      step();
      n_cmp++; if (ex_da !== 64'd0 || ex_db !== 64'd0) begin n_err++; $display("FAIL xzr_bypass got da=%h db=%h want 0", ex_da, ex_db); end
      idle(); if_valid = 1; rn = 31;
      step();
      n_cmp++; if (ex_da !== 64'd0) begin n_err++; $display("FAIL xzr_read got %h want 0", ex_da); end
   endtask

   task automatic test_load_use();
      idle(); if_valid = 1; mem_read = 1; rd = 7; rn = 1; rm = 2; uses_b = 1;
      step();
      n_cmp++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd7) begin n_err++; $display("FAIL lu_load got mr=%0d rd=%0d want 1 7", ex_mem_read, ex_rd); end
      idle(); if_valid = 1; rn = 7; rd = 9; ctrl_in = 8'h11; if_pc = 64'h200;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %0d want 1", stall); end
      step(); exp_cnt = exp_cnt + 1;
      n_cmp++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'd0 || ex_rd !== 5'd31 || ex_mem_read !== 1'b0)
         begin n_err++; $display("FAIL lu_bubble got v=%0d ctrl=%h rd=%0d mr=%0d want 0 0 31 0", ex_valid, ex_ctrl, ex_rd, ex_mem_read); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_one got %0d want 0", stall); end
      step();
      n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_ctrl !== 8'h11 || ex_pc !== 64'h200)
         begin n_err++; $display("FAIL lu_pass got v=%0d rd=%0d ctrl=%h pc=%h want 1 9 11 200", ex_valid, ex_rd, ex_ctrl, ex_pc); end
      n_cmp++; if (stall_cnt !== exp_cnt_out) begin n_err++; $display("FAIL lu_cnt got %0d want %0d", stall_cnt, exp_cnt_out); end
      // Port B dependence: counts only when uses_b is set
      idle(); if_valid = 1; mem_read = 1; rd = 8;
      step();
      idle(); if_valid = 1; rn = 1; rm = 8; uses_b = 0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_b_unused got %0d want 0", stall); end
      reg2loc = 1; rd = 8; rm = 2; uses_b = 1;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_b_reg2loc got %0d want 1", stall); end
      if_valid = 0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_if_invalid got %0d want 0", stall); end
      step();
      idle(); if_valid = 1; mem_read = 1; rd = 31;
      step();
      idle(); if_valid = 1; rn = 31;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_xzr got %0d want 0", stall); end
      step();
   endtask

   task automatic test_flush();
      idle(); if_valid = 1; mem_read = 1; rd = 7;
      step();
      idle(); if_valid = 1; rn = 7; rd = 4; ctrl_in = 8'h33; flush = 1;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got %0d want 0", stall); end
      step();
      n_cmp++; if (ex_valid !== 1'b0 || ex_rd !== 5'd31 || ex_ctrl !== 8'd0)
         begin n_err++; $display("FAIL fl_bubble got v=%0d rd=%0d ctrl=%h want 0 31 0", ex_valid, ex_rd, ex_ctrl); end
      n_cmp++; if (stall_cnt !== exp_cnt_out) begin n_err++; $display("FAIL fl_cnt got %0d want %0d", stall_cnt, exp_cnt_out); end
      flush = 0;
   endtask

   task automatic test_reset_mid_stall();
      idle(); if_valid = 1; mem_read = 1; rd = 7;
      step();
      idle(); if_valid = 1; rn = 7;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rms_pre got %0d want 1", stall); end
      reset = 1;
      step(); exp_cnt = '0;
      n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0)
         begin n_err++; $display("FAIL rms_clear got v=%0d mr=%0d rd=%0d want 0 0 0", ex_valid, ex_mem_read, ex_rd); end
      reset = 0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rms_stall got %0d want 0", stall); end
      n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rms_cnt got %0d want 0", stall_cnt); end
      step();
   endtask

   task automatic test_branch_bl();
      idle(); if_valid = 1; uncond_br = 1; br_addr = 26'h3FFFFFF;
      step();
      n_cmp++; if (ex_br_off !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL br_uncond got %h want fffffffffffffffc", ex_br_off); end
      idle(); if_valid = 1; cond_br_addr = 19'h40000; br_addr = 26'h0000123;
      step();
      n_cmp++; if (ex_br_off !== 64'hFFFF_FFFF_FFF0_0000) begin n_err++; $display("FAIL br_cond_neg got %h want fffffffffff00000", ex_br_off); end
      idle(); if_valid = 1; cond_br_addr = 19'h00005;
      step();
      n_cmp++; if (ex_br_off !== 64'h14) begin n_err++; $display("FAIL br_cond_pos got %h want 14", ex_br_off); end
      idle(); if_valid = 1; wb_we = 1; wb_addr = 30; wb_link_sel = 1; wb_link = 64'h104; wb_data = 64'h999;
      step();
      idle(); if_valid = 1; rn = 30;
      step();
      n_cmp++; if (ex_da !== 64'h104) begin n_err++; $display("FAIL bl_link got %h want 104", ex_da); end
   endtask

   initial begin
      test_reset();
      test_write_through();
      test_zero_reg();
      test_load_use();
      test_flush();
      test_reset_mid_stall();
      test_branch_bl();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised pipelined instruction-decode stage for the pipelined CPU.
- Sits between the IF/ID register and the execute stage.
- Contains:
  - the register file, with a zero register and write-through bypass
  - branch-offset sign extension and shift
  - load-use hazard detection, which generates a stall
  - an ID/EX pipeline register that supports stall bubbles and flush.
- Replaces the combinational single-cycle decode path with a registered one-cycle stage.

Parameters:
- WIDTH, 64, datapath and register width in bits.
- NUM_REGS, 32, register count. Index NUM_REGS-1 is the zero register (XZR).
- AW, $clog2(NUM_REGS), register address width.
- CTRL_W, 8, width of the opaque control bundle passed through to execute.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- if_valid  in  1  IF/ID holds a real instruction.
- if_pc  in  WIDTH  PC of the instruction in decode.
- rn, rm, rd  in  AW each  register fields.
- reg2loc  in  1  1: read port B address = rd; 0: read port B address = rm.
- uses_b  in  1  instruction actually consumes read port B.
- mem_read  in  1  instruction is a load.
- uncond_br  in  1  1: select br_addr; 0: select cond_br_addr.
- cond_br_addr  in  19  conditional-branch immediate.
- br_addr  in  26  unconditional-branch immediate.
- ctrl_in  in  CTRL_W  decoded control bundle.
- wb_we  in  1  write-back enable.
- wb_addr  in  AW  write-back register.
- wb_data  in  WIDTH  write-back data.
- wb_link_sel  in  1  1: write wb_link instead of wb_data (BL).
- wb_link  in  WIDTH  link value (PC+4 of the BL instruction).
- flush  in  1  squash the instruction in decode (branch resolved taken).
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX valid.
- ex_pc  out  WIDTH  registered PC.
- ex_da, ex_db  out  WIDTH  registered read data.
- ex_br_off  out  WIDTH  registered branch offset: sign-extended immediate << 2.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_rd  out  AW  registered destination register.
- ex_mem_read  out  1  registered load flag.
- stall_cnt  out  32  stall counter (see Optional Feature).

Behaviour:
- Register file:
  - NUM_REGS x WIDTH storage.
  - reset clears every entry to 0.
  - Write at the rising edge when wb_we=1 and wb_addr != XZR.
  - Write value is wb_link when wb_link_sel=1, otherwise wb_data.
  - Writes to XZR are ignored; XZR always reads 0.
- Read ports:
  - Both ports are combinational.
  - Port A address = rn. Port B address = reg2loc ? rd : rm.
  - Write-through: if wb_we=1, wb_addr==read address, and the address != XZR, the port returns the write value of the same cycle, not the stale entry.
- Branch offset:
  - Sign-extend the selected immediate to WIDTH, then shift left 2.
  - Bits shifted past bit WIDTH-1 are dropped.
- Load-use hazard, combinational:
  - haz = if_valid & ex_valid & ex_mem_read & (ex_rd != XZR) & ((ex_rd==rn) | (uses_b & ex_rd==port B address)).
  - stall = haz & ~flush.
- ID/EX register update, in priority order each rising edge:
  1. reset: all ex_* outputs = 0.
  2. flush: bubble (ex_valid=0, ex_ctrl=0, ex_mem_read=0, ex_rd=XZR); other fields don't-care (RTL writes 0).
  3. stall: bubble, identical to flush. IF holds, so the same instruction re-decodes next cycle and then passes.
  4. otherwise: load the current decode values, with ex_valid = if_valid.
- An invalid instruction (if_valid=0) loads ctrl and mem_read as 0.
- Latency: 1 cycle from decode to ex_*.
- A load followed by a dependent instruction costs exactly one bubble.
- stall output is 0 during reset and in the cycle after reset.
- Reset asserted mid-stall: the next edge clears ID/EX, so stall drops because ex_valid=0.
- flush and haz together: flush wins, stall=0, bubble inserted.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: 32-bit counter, cleared by reset.
  - Increments at each edge where stall=1.
  - Saturates at 0xFFFFFFFF.
  - Drives stall_cnt.
- Undefined: no counter logic; stall_cnt tied to 0.

Test Plan:
- Reset: assert reset 2 cycles -> all ex_* = 0, stall=0. Then read rn=5, rm=6 -> ex_da=0, ex_db=0.
- Write-through: wb_we=1, wb_addr=3, wb_data=0xDEAD, and decode rn=3 in the same cycle -> next cycle ex_da=0xDEAD. A later read of X3 also gives 0xDEAD.
- Zero register: wb_we=1, wb_addr=31, wb_data=0x55 -> a later read of rn=31 gives ex_da=0.
- Load-use: a load with rd=7, then rn=7 in decode -> stall=1 for exactly 1 cycle, one bubble (ex_valid=0). The dependent instruction appears the cycle after. stall_cnt=1 when ID_STALL_CNT_EN is defined.
- Flush priority: set up the load-use condition and assert flush=1 -> stall=0, ex_valid=0 next cycle, stall_cnt unchanged.
- Branch offset and BL:
  - uncond_br=1, br_addr=0x3FFFFFF -> ex_br_off = 0xFFFF_FFFF_FFFF_FFFC.
  - wb_link_sel=1, wb_link=0x104, wb_addr=30 -> a later read of X30 gives 0x104.
